// File: rtl/sram_ss_pkg.sv
// sram_ss_pkg
// Shared definitions for the SRAM island AHB-Lite phase controller:
//   state_t      - controller phase states
//   HTRANS_*     - AHB transfer type encodings
//   HRESP_*      - AHB response encodings
//   HSIZE_*      - AHB transfer size encodings
package sram_ss_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_D    = 3'd1,
        ST_RD_D    = 3'd2,
        ST_RD_CONF = 3'd3,
        ST_RD_FIN  = 3'd4,
        ST_ERR1    = 3'd5,
        ST_ERR2    = 3'd6
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/sram_ahb_phase_ctrl.sv
// sram_ahb_phase_ctrl
// AHB-Lite slave phase controller for one SRAM voltage island. Captures the
// address phase and produces the SRAM phase strobes, HREADYOUT and HRESP.
// A read whose address phase lands on a write data phase is deferred into
// its own data phase (one wait state) since the SRAM is single-ported.
// Illegal transfers get a two-cycle ERROR response and never touch the SRAM.
//
// Ports:
//   hclk, hresetn        clock, async active-low reset
//   hsel, htrans, hwrite, hready_in, haddr, hsize   AHB address phase inputs
//   haddr_reg, hsize_reg captured address/size
//   rd_aphase            read launched in address phase (combinational)
//   wr_dphase            write data phase
//   rd_dphase            read data phase
//   RW_conf_dphase       deferred read being issued from haddr_reg
//   hready_out, hresp    AHB slave response
module sram_ahb_phase_ctrl
    import sram_ss_pkg::*;
#(
    parameter bit ERR_ON_UNALIGNED = 1'b1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic        hready_in,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    output logic [31:0] haddr_reg,
    output logic [2:0]  hsize_reg,
    output logic        rd_aphase,
    output logic        wr_dphase,
    output logic        rd_dphase,
    output logic        RW_conf_dphase,
    output logic        hready_out,
    output logic [1:0]  hresp
);

    function automatic logic f_illegal(input logic [2:0] sz, input logic [1:0] a);
        logic w_bad;
        w_bad = (sz > HSIZE_WORD);
        if (ERR_ON_UNALIGNED)
            w_bad = w_bad | ((sz == HSIZE_HALF) & a[0])
                          | ((sz == HSIZE_WORD) & (a != 2'b00));
        return w_bad;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_illegal;
    logic [31:0] r_haddr;
    logic [2:0]  r_hsize;

    // htrans[1] covers NONSEQ and SEQ; IDLE and BUSY are never accepted.
    assign w_accept  = hsel & htrans[1] & hready_in;
    assign w_illegal = f_illegal(hsize, haddr[1:0]);

    // A read during a write data phase must wait: the SRAM port is busy with
    // the write, so the read is reissued from haddr_reg in RD_CONF instead.
    assign rd_aphase = w_accept & ~hwrite & ~w_illegal & (r_state != ST_WR_D) & hresetn;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
            r_haddr <= '0;
            r_hsize <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_haddr <= haddr;
                r_hsize <= hsize;
            end
        end
    end

    always_comb begin
        w_next = ST_IDLE;
        if (r_state == ST_RD_CONF)
            w_next = ST_RD_FIN;
        else if (w_accept) begin
            if (w_illegal)                w_next = ST_ERR1;
            else if (hwrite)              w_next = ST_WR_D;
            else if (r_state == ST_WR_D)  w_next = ST_RD_CONF;
            else                          w_next = ST_RD_D;
        end else if (r_state == ST_ERR1)
            w_next = ST_ERR2;
    end

    // Outputs decode straight from the state register.
    always_comb begin
        wr_dphase      = 1'b0;
        rd_dphase      = 1'b0;
        RW_conf_dphase = 1'b0;
        hready_out     = 1'b1;
        hresp          = HRESP_OKAY;
        unique case (r_state)
            ST_WR_D:    wr_dphase = 1'b1;
            ST_RD_D:    rd_dphase = 1'b1;
            ST_RD_CONF: begin
                rd_dphase      = 1'b1;
                RW_conf_dphase = 1'b1;
                hready_out     = 1'b0;
            end
            ST_RD_FIN:  rd_dphase = 1'b1;
            ST_ERR1: begin
                hready_out = 1'b0;
                hresp      = HRESP_ERROR;
            end
            ST_ERR2:    hresp = HRESP_ERROR;
            default:    ;
        endcase
    end

    assign haddr_reg = r_haddr;
    assign hsize_reg = r_hsize;

endmodule
